// File: rtl/seq_divider.sv
// Multi-cycle restoring divider with start/busy/done handshake, signed mode,
// and divide-by-zero / signed-overflow flags. One quotient bit per cycle.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DIV  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam int              CW         = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   COUNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0]   COUNT_ONE  = CW'(1);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
  localparam logic [WIDTH-1:0] MIN_VAL   = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] raw_q, raw_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] remd_q, remd_d;
  logic             dbz_out_q, dbz_out_d;
  logic             ovf_out_q, ovf_out_d;

  logic             dvd_neg, dvs_neg;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic [WIDTH:0]   rem_sh, trial;

  assign dvd_neg = signed_mode & dividend[WIDTH-1];
  assign dvs_neg = signed_mode & divisor[WIDTH-1];
  assign dvd_mag = dvd_neg ? (~dividend + ONE) : dividend;
  assign dvs_mag = dvs_neg ? (~divisor + ONE) : divisor;

  // Remainder is always below the divisor, so the shifted value needs one extra bit.
  assign rem_sh = {rem_q, quo_q[WIDTH-1]};
  assign trial  = rem_sh - {1'b0, dvs_q};

  always_comb begin
    // NOTE: every next-state signal gets a default first so no latch is inferred.
    state_d   = state_q;
    count_d   = count_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    raw_d     = raw_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    dbz_d     = dbz_q;
    ovf_d     = ovf_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    quot_d    = quot_q;
    remd_d    = remd_q;
    dbz_out_d = dbz_out_q;
    ovf_out_d = ovf_out_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          rem_d   = '0;
          quo_d   = dvd_mag;
          dvs_d   = dvs_mag;
          raw_d   = dividend;
          q_neg_d = dvd_neg ^ dvs_neg;
          r_neg_d = dvd_neg;
          dbz_d   = (divisor == '0);
          ovf_d   = signed_mode && (dividend == MIN_VAL) && (divisor == '1);
          count_d = COUNT_INIT;
          busy_d  = 1'b1;
          state_d = (divisor == '0) ? S_FIX : S_DIV;
        end
      end
      S_DIV: begin
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = rem_sh[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        count_d = count_q - COUNT_ONE;
        if (count_q == COUNT_ONE) state_d = S_FIX;
      end
      S_FIX: begin
        if (dbz_q) begin
          quot_d = '1;
          remd_d = raw_q;
        end else begin
          quot_d = q_neg_q ? (~quo_q + ONE) : quo_q;
          remd_d = r_neg_q ? (~rem_q + ONE) : rem_q;
        end
        dbz_out_d = dbz_q;
        ovf_out_d = ovf_q;
        done_d    = 1'b1;
        busy_d    = 1'b0;
        count_d   = '0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      raw_q     <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      dbz_q     <= 1'b0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      quot_q    <= '0;
      remd_q    <= '0;
      dbz_out_q <= 1'b0;
      ovf_out_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q   <= state_d;
      count_q   <= count_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      raw_q     <= raw_d;
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
      dbz_q     <= dbz_d;
      ovf_q     <= ovf_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      quot_q    <= quot_d;
      remd_q    <= remd_d;
      dbz_out_q <= dbz_out_d;
      ovf_out_q <= ovf_out_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = remd_q;
  assign div_by_zero = dbz_out_q;
  assign overflow    = ovf_out_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed WIDTH=8 vectors and handshake
// sequences, plus a random WIDTH=32 regression against an arithmetic model.
module tb_seq_divider;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic       start8, sm8, busy8, done8, dz8, ov8;
  logic [7:0] a8, b8, q8, r8;
  logic        start32, sm32, busy32, done32, dz32, ov32;
  logic [31:0] a32, b32, q32, r32;

  seq_divider #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(sm8),
    .dividend(a8), .divisor(b8), .busy(busy8), .done(done8),
    .quotient(q8), .remainder(r8), .div_by_zero(dz8), .overflow(ov8)
  );

  seq_divider #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .signed_mode(sm32),
    .dividend(a32), .divisor(b32), .busy(busy32), .done(done32),
    .quotient(q32), .remainder(r32), .div_by_zero(dz32), .overflow(ov32)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sm;
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    logic       ov;
  } vec_t;

  vec_t vecs[11];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural model: plain integer division on sign-interpreted operands.
  function automatic void ref_div(input int w, input logic [31:0] a, input logic [31:0] b,
                                  input logic sm, output logic [31:0] q, output logic [31:0] r,
                                  output logic dz, output logic ov);
    longint sa, sb, mask;
    mask = (longint'(1) << w) - 1;
    sa = longint'(a);
    sb = longint'(b);
    if (sm && a[w-1]) sa = sa - (longint'(1) << w);
    if (sm && b[w-1]) sb = sb - (longint'(1) << w);
    dz = (sb == 0);
    ov = sm && (sa == -(longint'(1) << (w - 1))) && (sb == -1);
    if (dz) begin
      q = 32'(mask);
      r = a;
    end else begin
      q = 32'((sa / sb) & mask);
      r = 32'((sa % sb) & mask);
    end
  endfunction

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic sm,
                      output int edges, output int busy_cnt);
    @(negedge clk);
    a8 = a; b8 = b; sm8 = sm; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    edges = 0;
    busy_cnt = busy8 ? 1 : 0;
    while (!done8 && edges < 60) begin
      @(posedge clk); #1;
      edges++;
      if (busy8) busy_cnt++;
    end
    check("done8_seen", done8, 1);
  endtask

  task automatic run32(input logic [31:0] a, input logic [31:0] b, input logic sm,
                       output int edges);
    @(negedge clk);
    a32 = a; b32 = b; sm32 = sm; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    edges = 0;
    while (!done32 && edges < 100) begin
      @(posedge clk); #1;
      edges++;
    end
    check("done32_seen", done32, 1);
  endtask

  task automatic wait_done8(output int edges);
    edges = 0;
    do begin
      @(posedge clk); #1;
      edges++;
    end while (!done8 && edges < 60);
    check("done8_wait", done8, 1);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int edges, busy_cnt, seen;
    logic [31:0] eq, er, ra, rb;
    logic edz, eov, rsm;

    vecs[0]  = '{8'd100, 8'd7,   1'b0, 8'd14,  8'd2,   1'b0, 1'b0};
    vecs[1]  = '{8'h9C,  8'h07,  1'b1, 8'hF2,  8'hFE,  1'b0, 1'b0};
    vecs[2]  = '{8'd100, 8'hF9,  1'b1, 8'hF2,  8'h02,  1'b0, 1'b0};
    vecs[3]  = '{8'h9C,  8'h07,  1'b0, 8'd22,  8'd2,   1'b0, 1'b0};
    vecs[4]  = '{8'd5,   8'd0,   1'b0, 8'hFF,  8'h05,  1'b1, 1'b0};
    vecs[5]  = '{8'd200, 8'd10,  1'b0, 8'd20,  8'd0,   1'b0, 1'b0};
    vecs[6]  = '{8'h80,  8'hFF,  1'b1, 8'h80,  8'h00,  1'b0, 1'b1};
    vecs[7]  = '{8'hFF,  8'hFF,  1'b0, 8'h01,  8'h00,  1'b0, 1'b0};
    vecs[8]  = '{8'hF9,  8'hFE,  1'b1, 8'h03,  8'hFF,  1'b0, 1'b0};
    vecs[9]  = '{8'h80,  8'h00,  1'b1, 8'hFF,  8'h80,  1'b1, 1'b0};
    vecs[10] = '{8'd7,   8'd9,   1'b0, 8'd0,   8'd7,   1'b0, 1'b0};

    rst_n = 1'b0;
    start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
    start32 = 1'b0; sm32 = 1'b0; a32 = '0; b32 = '0;
    #12;
    check("reset8_outputs", {busy8, done8, dz8, ov8, q8, r8}, 0);
    check("reset32_outputs", {busy32, done32, dz32, ov32, q32, r32}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      run8(vecs[i].a, vecs[i].b, vecs[i].sm, edges, busy_cnt);
      check($sformatf("vec%0d_quotient", i), q8, vecs[i].q);
      check($sformatf("vec%0d_remainder", i), r8, vecs[i].r);
      check($sformatf("vec%0d_div_by_zero", i), dz8, vecs[i].dz);
      check($sformatf("vec%0d_overflow", i), ov8, vecs[i].ov);
      check($sformatf("vec%0d_latency", i), edges, vecs[i].dz ? 1 : 9);
      check($sformatf("vec%0d_busy_cycles", i), busy_cnt, vecs[i].dz ? 1 : 9);
    end

    // Results and flags hold after the done pulse.
    repeat (3) @(posedge clk);
    #1;
    check("hold_done_low", done8, 0);
    check("hold_quotient", q8, 8'd0);
    check("hold_remainder", r8, 8'd7);

    // A second start during busy must be ignored.
    @(negedge clk);
    a8 = 8'd100; b8 = 8'd7; sm8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    a8 = 8'd50; b8 = 8'd3; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    check("ignored_start_busy", busy8, 1);
    wait_done8(edges);
    check("ignored_start_quotient", q8, 8'd14);
    check("ignored_start_remainder", r8, 8'd2);
    repeat (3) @(posedge clk);
    #1;
    check("ignored_start_not_queued", busy8, 0);

    // Start held high: operations repeat every WIDTH+2 cycles.
    @(negedge clk);
    a8 = 8'd100; b8 = 8'd7; sm8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    wait_done8(edges);
    wait_done8(edges);
    start8 = 1'b0;
    check("held_start_spacing", edges, 10);
    check("held_start_quotient", q8, 8'd14);
    repeat (2) @(posedge clk);
    #1;
    check("held_start_idle", busy8, 0);

    // Asynchronous reset during iteration 4 aborts the operation.
    @(negedge clk);
    a8 = 8'd100; b8 = 8'd7; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midop_reset_outputs", {busy8, done8, dz8, ov8, q8, r8}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done8 || busy8) seen++;
    end
    check("midop_reset_no_done", seen, 0);
    run8(8'd200, 8'd10, 1'b0, edges, busy_cnt);
    check("after_reset_quotient", q8, 8'd20);
    check("after_reset_remainder", r8, 8'd0);
    check("after_reset_latency", edges, 9);

    // Random regression at WIDTH=32 against the arithmetic model.
    for (int n = 0; n < 250; n++) begin
      ra  = $urandom;
      rsm = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; rsm = 1'b1; end
        2: rb = 32'($urandom_range(1, 15));
        3: rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
        4: rb = ra >> $urandom_range(1, 30);
        default: rb = $urandom;
      endcase
      run32(ra, rb, rsm, edges);
      ref_div(32, ra, rb, rsm, eq, er, edz, eov);
      check($sformatf("rand%0d_quotient a=%0h b=%0h s=%0d", n, ra, rb, rsm), q32, eq);
      check($sformatf("rand%0d_remainder", n), r32, er);
      check($sformatf("rand%0d_flags", n), {dz32, ov32}, {edz, eov});
      check($sformatf("rand%0d_latency", n), edges, edz ? 1 : 33);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
